pipe_stall_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage MIPS core. Generates the per-stage stall vector and flush.

---
 rtl/pipe_stall_ctrl.sv | 129 ++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall/flush sequencing for the 5-stage core
// Optional stall performance counter enabled by defining STALL_PERF_EN.
module pipe_stall_ctrl #(
  parameter int MC_LAT   = 4,
  parameter int MC_CNT_W = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_re1_i,
  input  logic       id_re2_i,
  input  logic [4:0] id_raddr1_i,
  input  logic [4:0] id_raddr2_i,
  input  logic       ex_we_i,
  input  logic [4:0] ex_waddr_i,
  input  logic       ex_is_load_i,
  input  logic       ex_mc_start_i,
  input  logic       flush_req_i,
  output logic [5:0] stall_o,
  output logic       flush_o,
  output logic       busy_o
`ifdef STALL_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt_o
`endif
);

  localparam logic [1:0] RUN    = 2'b00;
  localparam logic [1:0] MCWAIT = 2'b01;
  localparam logic [1:0] FLUSH  = 2'b10;

  localparam logic [5:0] LU_STALL = 6'b000111;
  localparam logic [5:0] MC_STALL = 6'b001111;
  localparam logic [MC_CNT_W-1:0] MC_INIT = MC_CNT_W'(MC_LAT - 1);
  localparam logic [MC_CNT_W-1:0] CNT_ONE = MC_CNT_W'(1);

  logic [1:0]          state_q, state_d;
  logic [MC_CNT_W-1:0] cnt_q, cnt_d;
  logic                load_use;

  // A load result is not available to ID until the load reaches MEM; $0 never carries a hazard.
  assign load_use = ex_is_load_i & ex_we_i & (ex_waddr_i != 5'd0) &
                    ((id_re1_i & (id_raddr1_i == ex_waddr_i)) |
                     (id_re2_i & (id_raddr2_i == ex_waddr_i)));

  assign busy_o = ~rst & (state_q != RUN);

  always_comb begin
    stall_o = 6'b000000;
    flush_o = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (rst) begin
      state_d = RUN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (flush_req_i) begin
            flush_o = 1'b1;
            state_d = FLUSH;
          end else if (ex_mc_start_i) begin
            stall_o = MC_STALL;
            if (MC_LAT > 1) begin
              cnt_d   = MC_INIT;
              state_d = MCWAIT;
            end
          end else if (load_use) begin
            stall_o = LU_STALL;
          end
        end
        MCWAIT: begin
          if (flush_req_i) begin
            flush_o = 1'b1;
            cnt_d   = '0;
            state_d = FLUSH;
          end else begin
            stall_o = MC_STALL;
            cnt_d   = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              state_d = RUN;
            end
          end
        end
        FLUSH: begin
          // Pipeline holds only bubbles here, so hazards and mc starts are moot.
          if (flush_req_i) begin
            flush_o = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef STALL_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (rst) begin
      perf_d = 32'd0;
    end else if (stall_o[0] && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    perf_q <= perf_d;
  end

  assign perf_stall_cnt_o = perf_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - scoreboard bench for pipe_stall_ctrl against a cycle reference model
module tb_pipe_stall_ctrl;
  localparam int MC_LAT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_re1, id_re2, ex_we, ex_is_load, ex_mc_start, flush_req;
  logic [4:0] id_raddr1, id_raddr2, ex_waddr;
  logic [5:0] stall;
  logic       flush, busy;
`ifdef STALL_PERF_EN
  logic [31:0] perf_cnt;
`endif

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.MC_LAT(MC_LAT), .MC_CNT_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_re1_i     (id_re1),
    .id_re2_i     (id_re2),
    .id_raddr1_i  (id_raddr1),
    .id_raddr2_i  (id_raddr2),
    .ex_we_i      (ex_we),
    .ex_waddr_i   (ex_waddr),
    .ex_is_load_i (ex_is_load),
    .ex_mc_start_i(ex_mc_start),
    .flush_req_i  (flush_req),
    .stall_o      (stall),
    .flush_o      (flush),
    .busy_o       (busy)
`ifdef STALL_PERF_EN
    ,
    .perf_stall_cnt_o(perf_cnt)
`endif
  );

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic        busy;
    logic [31:0] perf;
    int          tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  // Reference model: remaining multi-cycle stall cycles, pending flush recovery, stall count.
  int          mc_left  = 0;
  bit          recover  = 1'b0;
  logic [31:0] perf_ref = 32'd0;

  task automatic step(input bit r, input bit re1, input int a1, input bit re2, input int a2,
                      input bit we, input int wa, input bit ld, input bit mc, input bit fl,
                      input int tag);
    exp_t e;
    bit   hz;
    @(posedge clk);
    #1;
    rst = r; id_re1 = re1; id_raddr1 = 5'(a1); id_re2 = re2; id_raddr2 = 5'(a2);
    ex_we = we; ex_waddr = 5'(wa); ex_is_load = ld; ex_mc_start = mc; flush_req = fl;
    hz = ld && we && (wa != 0) && ((re1 && a1 == wa) || (re2 && a2 == wa));
    e.stall = 6'd0; e.flush = 1'b0; e.tag = tag; e.perf = perf_ref;
    e.busy  = !r && (mc_left > 0 || recover);
    if (r) begin
      mc_left = 0; recover = 1'b0;
    end else if (fl) begin
      e.flush = 1'b1; mc_left = 0; recover = 1'b1;
    end else if (recover) begin
      recover = 1'b0;
    end else if (mc_left > 0) begin
      e.stall = 6'b001111; mc_left--;
    end else if (mc) begin
      e.stall = 6'b001111; mc_left = MC_LAT - 1;
    end else if (hz) begin
      e.stall = 6'b000111;
    end
    if (r) perf_ref = 32'd0;
    else if (e.stall[0] && perf_ref != 32'hFFFF_FFFF) perf_ref = perf_ref + 32'd1;
    sb.push_back(e);
  endtask

  task automatic idle(input int tag);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) break;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (stall !== e.stall) begin
          errors++;
          $display("FAIL stall tag=%0d t=%0t got=%b exp=%b", e.tag, $time, stall, e.stall);
        end
        checks++;
        if (flush !== e.flush) begin
          errors++;
          $display("FAIL flush tag=%0d t=%0t got=%b exp=%b", e.tag, $time, flush, e.flush);
        end
        checks++;
        if (busy !== e.busy) begin
          errors++;
          $display("FAIL busy tag=%0d t=%0t got=%b exp=%b", e.tag, $time, busy, e.busy);
        end
`ifdef STALL_PERF_EN
        checks++;
        if (perf_cnt !== e.perf) begin
          errors++;
          $display("FAIL perf tag=%0d t=%0t got=%0d exp=%0d", e.tag, $time, perf_cnt, e.perf);
        end
`endif
      end
    end
  end

  initial begin : stim
    id_re1 = 0; id_re2 = 0; id_raddr1 = 0; id_raddr2 = 0; ex_we = 0; ex_waddr = 0;
    ex_is_load = 0; ex_mc_start = 0; flush_req = 0;
    repeat (2) @(posedge clk);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0);
    // T1 load-use on port 1, then port 2
    step(0, 1, 3, 0, 0, 1, 3, 1, 0, 0, 1);
    idle(1);
    step(0, 0, 0, 1, 7, 1, 7, 1, 0, 0, 1);
    // T2 $0 destination and disabled port
    step(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 2);
    step(0, 0, 5, 0, 5, 1, 5, 1, 0, 0, 2);
    step(0, 1, 5, 0, 0, 0, 5, 1, 0, 0, 2);
    // T3 multi-cycle pulse
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3);
    repeat (5) idle(3);
    // T4 flush in second MCWAIT cycle
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4);
    idle(4);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
    repeat (2) idle(4);
    // T5 flush beats mc start and load-use
    step(0, 1, 2, 0, 0, 1, 2, 1, 1, 1, 5);
    repeat (2) idle(5);
    // T6 reset during MCWAIT with cnt=2
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6);
    idle(6);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6);
    repeat (2) idle(6);
    // Randomized traffic; small address range keeps hazards frequent
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) == 0, 1'($urandom), $urandom_range(0, 3),
           1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3) != 0,
           $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 9) == 0,
           $urandom_range(0, 15) == 0, 100);
    end
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d exp=0", sb.size());
    end
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog t=%0t exp=finish", $time);
    $fatal(1, "timeout");
  end
endmodule
